// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Round-robin arbiter that shares the single GRF write port between NREQ
//   writeback sources. At most one request is granted per cycle. The granted
//   payload is registered into a one-entry output stage that drives the GRF
//   write port. The block also flags read-after-write hazards for both GRF
//   read ports against pending writes: those still being requested and the
//   one sitting in the output stage.
//
// Ports
//   clk, reset        clock (posedge) and asynchronous active-low reset
//   hold              freeze: no grants this cycle, rr pointer frozen
//   req_valid/ready   per-requester handshake (ready is a one-hot grant)
//   req_addr/data/pc  packed per-requester payloads, slice i at [i*W +: W]
//   grf_we/waddr/wdata/pc  registered GRF write port
//   rd_addr1/2        GRF read addresses to check for hazards
//   raw_hit1/2        pending write to the corresponding read address
module grf_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ*DW-1:0] req_pc,
   output logic               grf_we,
   output logic [AW-1:0]      grf_waddr,
   output logic [DW-1:0]      grf_wdata,
   output logic [DW-1:0]      grf_pc,
   input  logic [AW-1:0]      rd_addr1,
   input  logic [AW-1:0]      rd_addr2,
   output logic               raw_hit1,
   output logic               raw_hit2
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] ge_mask;
   logic [NREQ-1:0] masked;
   logic [NREQ-1:0] first_masked;
   logic [NREQ-1:0] first_any;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] hit1_vec;
   logic [NREQ-1:0] hit2_vec;
   logic            xfer;

   // Bit-transposed AND terms: row j holds bit j of every requester's
   // payload gated by its grant, so each selected bit is a plain OR-reduce.
   logic [AW-1:0][NREQ-1:0] addr_t;
   logic [DW-1:0][NREQ-1:0] data_t;
   logic [DW-1:0][NREQ-1:0] pc_t;
   logic [PW-1:0][NREQ-1:0] ptr_t;

   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic [DW-1:0] sel_pc;
   logic [PW-1:0] next_ptr;

   // Requesters at or above rr_ptr get first pick; if none of them is valid
   // the search wraps around to the lowest valid index overall.
   assign ge_mask = ~((NREQ'(1) << rr_ptr) - NREQ'(1));
   assign masked  = req_valid & ge_mask;

   genvar gi, gj;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign first_masked[gi] = masked[gi]    & ~|(masked    & NREQ'((1 << gi) - 1));
         assign first_any[gi]    = req_valid[gi] & ~|(req_valid & NREQ'((1 << gi) - 1));

         assign hit1_vec[gi] = req_valid[gi] & (req_addr[gi*AW +: AW] == rd_addr1);
         assign hit2_vec[gi] = req_valid[gi] & (req_addr[gi*AW +: AW] == rd_addr2);

         for (gj = 0; gj < AW; gj++) begin : g_addr
            assign addr_t[gj][gi] = grant[gi] & req_addr[gi*AW + gj];
         end
         for (gj = 0; gj < DW; gj++) begin : g_data
            assign data_t[gj][gi] = grant[gi] & req_data[gi*DW + gj];
            assign pc_t[gj][gi]   = grant[gi] & req_pc[gi*DW + gj];
         end
         // Pointer value after serving index gi is (gi+1) mod NREQ.
         for (gj = 0; gj < PW; gj++) begin : g_ptr
            assign ptr_t[gj][gi] = grant[gi] & (((((gi + 1) % NREQ) >> gj) % 2) == 1);
         end
      end

      for (gj = 0; gj < AW; gj++) begin : g_sel_addr
         assign sel_addr[gj] = |addr_t[gj];
      end
      for (gj = 0; gj < DW; gj++) begin : g_sel_data
         assign sel_data[gj] = |data_t[gj];
         assign sel_pc[gj]   = |pc_t[gj];
      end
      for (gj = 0; gj < PW; gj++) begin : g_sel_ptr
         assign next_ptr[gj] = |ptr_t[gj];
      end
   endgenerate

   // Grant is suppressed during reset as well, so nothing is accepted that
   // the output stage would immediately throw away.
   assign grant     = (!reset || hold) ? '0 : ((|masked) ? first_masked : first_any);
   assign req_ready = grant;
   assign xfer      = |grant;

   // $0 never causes a hazard: it is never written.
   assign raw_hit1 = (rd_addr1 != '0) & ((grf_we & (grf_waddr == rd_addr1)) | (|hit1_vec));
   assign raw_hit2 = (rd_addr2 != '0) & ((grf_we & (grf_waddr == rd_addr2)) | (|hit2_vec));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         grf_we    <= 1'b0;
         grf_waddr <= '0;
         grf_wdata <= '0;
         grf_pc    <= '0;
      end else begin
         if (xfer) begin
            rr_ptr    <= next_ptr;
            grf_we    <= (sel_addr != '0);
            grf_waddr <= sel_addr;
            grf_wdata <= sel_data;
            grf_pc    <= sel_pc;
         end else begin
            grf_we    <= 1'b0;
         end
      end
   end

endmodule
